lcd_capture: RTL and testbench

- Receiver end of the PPU pixel-output stream.
- Accepts one pixel per valid cycle in raster order (line 0..143, x 0..159), maps each 2-bit colour index through the selected palette, and stores the resulting shade in a frame buffer.
- Exposes a synchronous random-access read port so a host or testbench can dump complete frames.
- Sits between the PPU pixel pipeline and the LCD model/frame dumper.

---
 rtl/lcd_capture_pkg.sv | 28 ++
 rtl/lcd_capture_ram.sv | 29 ++
 rtl/lcd_capture.sv | 152 +++++++++++++++
 tb/tb_lcd_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_capture_pkg.sv
// rtl/lcd_capture_pkg.sv - shared video types and palette lookup for the LCD capture path
package video_types;

  typedef logic [1:0] Pixel;
  typedef logic [7:0] Pallete;

  localparam int LCD_LINEWIDTH  = 160;
  localparam int LCD_LINES      = 144;
  localparam int LCD_LINES_BITS = 8;

  typedef enum logic [1:0] {WAIT_SYNC, CAPTURE, HOLD} CaptureState;
  typedef enum logic [1:0] {BG, OBP0, OBP1, BYPASS} PaletteSel;

  // Bypass behaves like the identity palette 0xE4, so the index is the shade.
  function automatic Pixel pal_lookup(input Pixel idx, input PaletteSel sel,
                                      input Pallete bgp, input Pallete obp0,
                                      input Pallete obp1);
    Pallete r;
    case (sel)
      BG:      r = bgp;
      OBP0:    r = obp0;
      OBP1:    r = obp1;
      default: r = 8'hE4;
    endcase
    return r[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/lcd_capture_ram.sv
// rtl/lcd_capture_ram.sv - 1-write / 1-synchronous-read 2-bit frame buffer RAM
module lcd_capture_ram
  import video_types::*;
#(
  parameter int DEPTH = LCD_LINEWIDTH * LCD_LINES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  Pixel          wr_data,
  input  logic [AW-1:0] rd_addr,
  output Pixel          rd_data
);

  Pixel mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Same-address read and write in one cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lcd_capture.sv
// rtl/lcd_capture.sv - PPU pixel stream capture into a frame buffer; LCD_CAPTURE_DOUBLE_BUFFER_EN selects double buffering
module lcd_capture
  import video_types::*;
#(
  parameter int LINEWIDTH = LCD_LINEWIDTH,
  parameter int LINES     = LCD_LINES,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [1:0]       pix_idx,
  input  logic [1:0]       pix_pal,
  input  logic             frame_start,
  input  logic [7:0]       bgp,
  input  logic [7:0]       obp0,
  input  logic [7:0]       obp1,
  input  logic [7:0]       rd_line,
  input  logic [7:0]       rd_x,
  output logic [1:0]       rd_data,
  output logic             frame_ready,
  output logic [CNT_W-1:0] frame_count,
  output logic             capturing,
  output logic             err_short,
  output logic             err_overflow,
  input  logic             err_clr
);

  localparam int DEPTH = LINEWIDTH * LINES;
  localparam int AW    = $clog2(DEPTH);

  CaptureState              state, state_n;
  logic [LCD_LINES_BITS-1:0] x, y, x_n, y_n;
  logic                     we, set_short, set_over, done;
  logic [AW-1:0]            wr_addr, rd_addr;
  logic                     rd_oob, rd_oob_q;
  Pixel                     shade, ram_q;

  assign shade = pal_lookup(pix_idx, PaletteSel'(pix_pal), bgp, obp0, obp1);

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_SYNC;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    we        = 1'b0;
    set_short = 1'b0;
    set_over  = 1'b0;
    done      = 1'b0;
    wr_addr   = '0;
    case (state)
      WAIT_SYNC, HOLD: begin
        if (pix_valid && frame_start) begin
          we      = 1'b1;
          x_n     = 8'd1;
          y_n     = 8'd0;
          state_n = CAPTURE;
        end else if (pix_valid && state == HOLD) begin
          set_over = 1'b1;
        end
      end
      CAPTURE: begin
        if (pix_valid) begin
          we = 1'b1;
          if (frame_start) begin
            // A sync at the very first position is a clean start, not a short frame.
            set_short = (x != '0) || (y != '0);
            x_n       = 8'd1;
            y_n       = 8'd0;
          end else begin
            wr_addr = AW'(int'(y) * LINEWIDTH + int'(x));
            if (int'(x) == LINEWIDTH - 1) begin
              x_n = '0;
              if (int'(y) == LINES - 1) begin
                y_n     = '0;
                done    = 1'b1;
                state_n = HOLD;
              end else begin
                y_n = y + 8'd1;
              end
            end else begin
              x_n = x + 8'd1;
            end
          end
        end
      end
      default: state_n = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x            <= '0;
      y            <= '0;
      frame_ready  <= 1'b0;
      frame_count  <= '0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
      rd_oob_q     <= 1'b0;
    end else begin
      x            <= x_n;
      y            <= y_n;
      frame_ready  <= done;
      if (done) frame_count <= frame_count + CNT_W'(1);
      err_short    <= set_short | (err_short & ~err_clr);
      err_overflow <= set_over | (err_overflow & ~err_clr);
      rd_oob_q     <= rd_oob;
    end
  end

  assign capturing = (state == CAPTURE);
  assign rd_oob    = (int'(rd_line) >= LINES) || (int'(rd_x) >= LINEWIDTH);
  assign rd_addr   = rd_oob ? '0 : AW'(int'(rd_line) * LINEWIDTH + int'(rd_x));
  assign rd_data   = rd_oob_q ? 2'd0 : ram_q;

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  logic front, front_q;
  Pixel q0, q1;

  // front flips on the same edge that raises frame_ready; aborted frames never flip it.
  always_ff @(posedge clk) begin
    if (reset) begin
      front   <= 1'b0;
      front_q <= 1'b0;
    end else begin
      if (done) front <= ~front;
      front_q <= front;
    end
  end

  lcd_capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram0 (
    .clk(clk), .reset(reset), .we(we & front), .wr_addr(wr_addr),
    .wr_data(shade), .rd_addr(rd_addr), .rd_data(q0)
  );
  lcd_capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram1 (
    .clk(clk), .reset(reset), .we(we & ~front), .wr_addr(wr_addr),
    .wr_data(shade), .rd_addr(rd_addr), .rd_data(q1)
  );

  assign ram_q = front_q ? q1 : q0;
`else
  lcd_capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr),
    .wr_data(shade), .rd_addr(rd_addr), .rd_data(ram_q)
  );
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// tb/tb_lcd_capture.sv - scoreboard bench for lcd_capture
module tb_lcd_capture;

  localparam bit DB =
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    1'b1;
`else
    1'b0;
`endif

  localparam int K_RD = 0, K_FC = 1, K_ES = 2, K_EO = 3, K_CAP = 4, K_PULSE = 5;

  logic        clk = 1'b0;
  logic        reset, pix_valid, frame_start, err_clr;
  logic [1:0]  pix_idx, pix_pal, rd_data;
  logic [7:0]  bgp, obp0, obp1, rd_line, rd_x;
  logic        frame_ready, capturing, err_short, err_overflow;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  lcd_capture dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_idx(pix_idx),
    .pix_pal(pix_pal), .frame_start(frame_start), .bgp(bgp), .obp0(obp0),
    .obp1(obp1), .rd_line(rd_line), .rd_x(rd_x), .rd_data(rd_data),
    .frame_ready(frame_ready), .frame_count(frame_count), .capturing(capturing),
    .err_short(err_short), .err_overflow(err_overflow), .err_clr(err_clr)
  );

  int    kind_q[$];
  int    val_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    fr_cnt = 0;
  logic  req = 1'b0;

  initial begin
    logic  pend;
    int    k, v, act;
    string t;
    forever begin
      @(posedge clk);
      pend = req;
      @(negedge clk);
      if (frame_ready === 1'b1) fr_cnt++;
      if (pend) begin
        n_cmp++;
        if (kind_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_underflow: got a check request, expected queue empty");
        end else begin
          k = kind_q.pop_front();
          v = val_q.pop_front();
          t = tag_q.pop_front();
          case (k)
            K_RD:    act = int'(rd_data);
            K_FC:    act = int'(frame_count);
            K_ES:    act = int'(err_short);
            K_EO:    act = int'(err_overflow);
            K_CAP:   act = int'(capturing);
            default: act = fr_cnt;
          endcase
          if (act != v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", t, act, v);
          end
        end
      end
    end
  end

  task automatic expect_st(input int k, input int v, input string t);
    kind_q.push_back(k);
    val_q.push_back(v);
    tag_q.push_back(t);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic expect_rd(input int l, input int x, input int v, input string t);
    rd_line = 8'(l);
    rd_x    = 8'(x);
    expect_st(K_RD, v, t);
  endtask

  task automatic pix(input int idx, input int pal, input bit fs);
    pix_valid   = 1'b1;
    pix_idx     = 2'(idx);
    pix_pal     = 2'(pal);
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    err_clr     = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; err_clr = 1'b0;
    pix_idx = '0; pix_pal = '0; bgp = 8'hE4; obp0 = 8'h00; obp1 = 8'h00;
    rd_line = '0; rd_x = '0;
    @(posedge clk); #1;
    expect_st(K_RD, 0, "rst_rd_data");
    expect_st(K_FC, 0, "rst_frame_count");
    expect_st(K_ES, 0, "rst_err_short");
    expect_st(K_EO, 0, "rst_err_overflow");
    expect_st(K_CAP, 0, "rst_capturing");
    reset = 1'b0;

    // Frame 1: idx=(x+y)%4 through identity BG palette
    for (int y = 0; y < 144; y++)
      for (int x = 0; x < 160; x++)
        pix((x + y) % 4, 0, (x == 0) && (y == 0));
    idle();
    expect_st(K_PULSE, 1, "f1_pulses");
    expect_st(K_FC, 1, "f1_frame_count");
    expect_st(K_CAP, 0, "f1_hold");
    expect_rd(10, 3, 1, "f1_rd_10_3");
    expect_rd(143, 159, 2, "f1_rd_last");
    expect_rd(0, 1, 1, "f1_rd_0_1");

    // Overflow: pixels in HOLD without frame_start are dropped
    repeat (5) pix(3, 3, 1'b0);
    idle();
    expect_st(K_EO, 1, "ovf_set");
    expect_st(K_FC, 1, "ovf_frame_count");
    expect_rd(0, 1, 1, "ovf_rd_0_1");
    expect_rd(0, 2, 2, "ovf_rd_0_2");
    err_clr = 1'b1;
    pix(3, 3, 1'b0);
    idle();
    expect_st(K_EO, 1, "ovf_err_beats_clr");
    err_clr = 1'b1;
    @(posedge clk); #1;
    idle();
    expect_st(K_EO, 0, "ovf_cleared");

    // Short frame: 500 pixels of shade 3, then a mid-frame sync with shade 2
    pix(3, 3, 1'b1);
    repeat (499) pix(3, 3, 1'b0);
    pix(2, 3, 1'b1);
    idle();
    expect_st(K_ES, 1, "short_set");
    expect_st(K_FC, 1, "short_frame_count");
    expect_st(K_PULSE, 1, "short_no_pulse");
    expect_st(K_CAP, 1, "short_capturing");
    expect_rd(0, 0, DB ? 0 : 2, "short_rd_0_0");
    expect_rd(0, 1, DB ? 1 : 3, "short_rd_0_1");
    err_clr = 1'b1;
    @(posedge clk); #1;
    idle();
    expect_st(K_ES, 0, "short_cleared");

    // Reset at pixel 10000 of the restarted frame
    repeat (9999) pix(1, 3, 1'b0);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expect_st(K_CAP, 0, "rst_mid_capturing");
    expect_st(K_FC, 0, "rst_mid_frame_count");
    expect_st(K_PULSE, 1, "rst_mid_no_pulse");

    // Frame A: bgp=0x1B, idx 0 -> 3; three special pixels exercise OBP0, OBP1, bypass
    bgp = 8'h1B; obp0 = 8'h08; obp1 = 8'h40;
    for (int y = 0; y < 144; y++)
      for (int x = 0; x < 160; x++) begin
        if (x == 7 && y == 7)          pix(1, 1, 1'b0);
        else if (x == 8 && y == 8)     pix(3, 2, 1'b0);
        else if (x == 159 && y == 143) pix(2, 3, 1'b0);
        else                           pix(0, 0, (x == 0) && (y == 0));
      end
    idle();
    expect_st(K_FC, 1, "fa_frame_count");
    expect_st(K_PULSE, 2, "fa_pulses");
    expect_rd(0, 0, 3, "fa_rd_0_0");
    expect_rd(50, 77, 3, "fa_rd_50_77");
    expect_rd(7, 7, 2, "fa_rd_obp0");
    expect_rd(8, 8, 1, "fa_rd_obp1");
    expect_rd(143, 159, 2, "fa_rd_bypass");
    expect_rd(144, 0, 0, "fa_rd_oob_line");
    expect_rd(0, 160, 0, "fa_rd_oob_x");
    expect_rd(255, 255, 0, "fa_rd_oob_both");

    // Frame B: shade 1, checked half-written and complete
    pix(1, 3, 1'b1);
    repeat (11519) pix(1, 3, 1'b0);
    idle();
    expect_st(K_CAP, 1, "fb_half_capturing");
    expect_st(K_FC, 1, "fb_half_frame_count");
    expect_rd(0, 0, DB ? 3 : 1, "fb_half_rd_0_0");
    expect_rd(71, 159, DB ? 3 : 1, "fb_half_rd_71_159");
    expect_rd(143, 0, 3, "fb_half_rd_143_0");
    repeat (11520) pix(1, 3, 1'b0);
    idle();
    expect_st(K_FC, 2, "fb_frame_count");
    expect_st(K_PULSE, 3, "fb_pulses");
    expect_st(K_CAP, 0, "fb_hold");
    expect_rd(0, 0, 1, "fb_rd_0_0");
    expect_rd(100, 50, 1, "fb_rd_100_50");
    expect_rd(143, 159, 1, "fb_rd_last");

    repeat (4) @(posedge clk);
    if (kind_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", kind_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
